// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature step batcher.
// Latency: n/a (types and a pure combinational helper function).
// Backpressure: n/a.
package quad_pkg;

   // Control FSM: INIT lets synchronizers and debouncers settle, RUN decodes.
   typedef enum logic {
      INIT,
      RUN
   } state_t;

   // Quadrature phase codes {a,b}, listed in forward order.
   localparam logic [1:0] PH_00 = 2'b00;
   localparam logic [1:0] PH_01 = 2'b01;
   localparam logic [1:0] PH_11 = 2'b11;
   localparam logic [1:0] PH_10 = 2'b10;

   typedef enum logic [1:0] {
      NONE,
      FWD,
      REV,
      ILLEGAL
   } step_t;

   // Classify one transition of the debounced phase pair.
   // Gray-code property: a legal step flips exactly one bit, so a two-bit
   // flip cannot be attributed to either direction.
   function automatic step_t step_dir(input logic [1:0] prev, input logic [1:0] curr);
      logic [1:0] fwd_next;
      case (prev)
         PH_00:   fwd_next = PH_01;
         PH_01:   fwd_next = PH_11;
         PH_11:   fwd_next = PH_10;
         default: fwd_next = PH_00;
      endcase
      if (curr == prev) begin
         step_dir = NONE;
      end else if ((curr ^ prev) == 2'b11) begin
         step_dir = ILLEGAL;
      end else if (curr == fwd_next) begin
         step_dir = FWD;
      end else begin
         step_dir = REV;
      end
   endfunction

endpackage

// File: rtl/debounce_sync.sv
// One-bit synchronizer followed by a run-length debouncer.
// Latency: SYNC_STAGES cycles to the synced level, then DEBOUNCE cycles of disagreement before level_o follows.
// Backpressure: none; free-running on every clock.
//
// Ports:
//   clk     - system clock
//   rst_n   - asynchronous active-low reset (clears chain, level and run counter)
//   din_i   - raw asynchronous input
//   level_o - debounced, synchronous level
module debounce_sync #(
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din_i,
   output logic level_o
);

   localparam int CW = $clog2(DEBOUNCE + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic                   deb_q, deb_d;
   logic [CW-1:0]          run_q, run_d;

   // Plain flop chain, nothing between stages, so metastability has a full
   // cycle per stage to resolve.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];

   // The run counter measures consecutive cycles of disagreement with the
   // current debounced level; the level flips on the DEBOUNCE-th one. The
   // synced value need not be constant during the run, only different.
   always_comb begin
      deb_d = deb_q;
      run_d = '0;
      if (synced != deb_q) begin
         if (run_q == CW'(DEBOUNCE - 1)) begin
            deb_d = synced;
         end else begin
            run_d = run_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         deb_q <= 1'b0;
         run_q <= '0;
      end else begin
         deb_q <= deb_d;
         run_q <= run_d;
      end
   end

   assign level_o = deb_q;

endmodule

// File: rtl/quad_step_batcher.sv
// Quadrature decoder that batches steps per window into a net up/down value for an accumulator.
// Latency: outputs registered one cycle after the terminal window cycle; input-to-step delay is SYNC_STAGES+DEBOUNCE+1.
// Backpressure: none; the accumulator must accept the one-cycle emit pulse unconditionally.
//
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   qa, qb      - encoder phases, asynchronous to clk
//   enable      - runs the window counter and allows steps to be counted
//   clear_req   - one-cycle request to clear the accumulator at the next emit
//   up, down    - net step magnitude for the closed window, only one nonzero
//   clear       - pulse coincident with the emit cycle
//   err_count   - saturating count of illegal two-bit transitions
module quad_step_batcher
   import quad_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 4,
   parameter int WINDOW      = 16,
   parameter int WIDTH       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             qa,
   input  logic             qb,
   input  logic             enable,
   input  logic             clear_req,
   output logic [WIDTH-1:0] up,
   output logic [WIDTH-1:0] down,
   output logic             clear,
   output logic [7:0]       err_count
);

   localparam int CW          = $clog2(WINDOW + 1);
   localparam int WW          = $clog2(WINDOW);
   localparam int INIT_CYCLES = SYNC_STAGES + DEBOUNCE;
   localparam int IW          = $clog2(INIT_CYCLES + 1);

   // ------------------------------------------------------------------
   // Input conditioning
   // ------------------------------------------------------------------
   logic deb_a, deb_b;

   debounce_sync #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE   (DEBOUNCE)
   ) u_deb_a (
      .clk    (clk),
      .rst_n  (rst_n),
      .din_i  (qa),
      .level_o(deb_a)
   );

   debounce_sync #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE   (DEBOUNCE)
   ) u_deb_b (
      .clk    (clk),
      .rst_n  (rst_n),
      .din_i  (qb),
      .level_o(deb_b)
   );

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t            state_q, state_d;
   logic [IW-1:0]     init_cnt_q, init_cnt_d;
   logic [1:0]        prev_q, prev_d;
   logic [WW-1:0]     win_q, win_d;
   logic [CW-1:0]     fwd_q, fwd_d;
   logic [CW-1:0]     rev_q, rev_d;
   logic [7:0]        err_q, err_d;
   logic              pend_q, pend_d;
   logic [WIDTH-1:0]  up_q, up_d;
   logic [WIDTH-1:0]  down_q, down_d;
   logic              clear_q, clear_d;

   logic [1:0]        curr;
   step_t             dir;
   logic              count_en;
   logic              terminal;
   logic [CW-1:0]     fwd_tot, rev_tot;

   assign curr     = {deb_a, deb_b};
   assign dir      = step_dir(prev_q, curr);
   assign count_en = (state_q == RUN) && enable;
   assign terminal = count_en && (win_q == WW'(WINDOW - 1));

   // Batch totals including this cycle's step, so a step decoded in the
   // terminal cycle lands in the window that is closing.
   always_comb begin
      fwd_tot = fwd_q;
      rev_tot = rev_q;
      if (count_en && (dir == FWD) && (fwd_q != '1)) begin
         fwd_tot = fwd_q + 1'b1;
      end
      if (count_en && (dir == REV) && (rev_q != '1)) begin
         rev_tot = rev_q + 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      prev_d     = curr;                 // prev always tracks the debounced pair
      win_d      = win_q;
      fwd_d      = fwd_q;
      rev_d      = rev_q;
      err_d      = err_q;
      pend_d     = pend_q | clear_req;
      up_d       = '0;
      down_d     = '0;
      clear_d    = 1'b0;

      case (state_q)
         INIT: begin
            // Transitions are ignored while the conditioning pipeline fills;
            // prev is still loaded so the first RUN cycle sees no false step.
            if (init_cnt_q == IW'(INIT_CYCLES - 1)) begin
               state_d = RUN;
            end else begin
               init_cnt_d = init_cnt_q + 1'b1;
            end
         end

         RUN: begin
            // Illegal transitions are counted regardless of enable.
            if ((dir == ILLEGAL) && (err_q != 8'hFF)) begin
               err_d = err_q + 8'd1;
            end
            fwd_d = fwd_tot;
            rev_d = rev_tot;
            if (enable) begin
               if (terminal) begin
                  win_d = '0;
                  // Only the net magnitude leaves the block, which keeps up
                  // and down mutually exclusive by construction.
                  if (fwd_tot >= rev_tot) begin
                     up_d = WIDTH'(fwd_tot - rev_tot);
                  end else begin
                     down_d = WIDTH'(rev_tot - fwd_tot);
                  end
                  // A request on the terminal cycle rides this emit.
                  clear_d = pend_q | clear_req;
                  pend_d  = 1'b0;
                  fwd_d   = '0;
                  rev_d   = '0;
               end else begin
                  win_d = win_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = INIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= INIT;
         init_cnt_q <= '0;
         prev_q     <= '0;
         win_q      <= '0;
         fwd_q      <= '0;
         rev_q      <= '0;
         err_q      <= '0;
         pend_q     <= 1'b1;             // first window after reset always clears
         up_q       <= '0;
         down_q     <= '0;
         clear_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         prev_q     <= prev_d;
         win_q      <= win_d;
         fwd_q      <= fwd_d;
         rev_q      <= rev_d;
         err_q      <= err_d;
         pend_q     <= pend_d;
         up_q       <= up_d;
         down_q     <= down_d;
         clear_q    <= clear_d;
      end
   end

   assign up        = up_q;
   assign down      = down_q;
   assign clear     = clear_q;
   assign err_count = err_q;

endmodule

// File: tb/tb_quad_step_batcher.sv
// Bench for quad_step_batcher: directed encoder scenarios followed by random motion.
// Latency: first emit expected SYNC_STAGES+DEBOUNCE+WINDOW clocks after reset release.
// Backpressure: n/a.
module tb_quad_step_batcher;

   localparam int S  = 2;
   localparam int D  = 4;
   localparam int W  = 48;   // wide enough to hold 7 steps held 6 cycles each
   localparam int WD = 32;
   localparam int N  = S + D;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          qa = 1'b0, qb = 1'b0;
   logic          enable = 1'b0, clear_req = 1'b0;
   logic [WD-1:0] up, down;
   logic          clear;
   logic [7:0]    err_count;

   quad_step_batcher #(
      .SYNC_STAGES(S), .DEBOUNCE(D), .WINDOW(W), .WIDTH(WD)
   ) dut (
      .clk(clk), .rst_n(rst_n), .qa(qa), .qb(qb), .enable(enable),
      .clear_req(clear_req), .up(up), .down(down), .clear(clear),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: raw samples delayed through a queue, debounced by
   // run length, steps derived from phase position differences mod 4,
   // windows closed after W enabled RUN cycles.
   // ------------------------------------------------------------------
   bit aq[$], bq[$];
   bit m_deb_a, m_deb_b, m_prev_a, m_prev_b;
   int m_run_a, m_run_b, m_cnt, m_win, m_f, m_r, m_err;
   bit m_pend, m_clr, m_emit;
   int m_up, m_down;

   function automatic int pos_of(input bit a, input bit b);
      case ({a, b})
         2'b00:   return 0;
         2'b01:   return 1;
         2'b11:   return 2;
         default: return 3;
      endcase
   endfunction

   task automatic model_reset();
      aq.delete(); bq.delete();
      m_deb_a = 0; m_deb_b = 0; m_prev_a = 0; m_prev_b = 0;
      m_run_a = 0; m_run_b = 0; m_cnt = 0; m_win = 0; m_f = 0; m_r = 0;
      m_err = 0; m_pend = 1; m_clr = 0; m_emit = 0; m_up = 0; m_down = 0;
   endtask

   task automatic model_step(input bit a, input bit b, input bit en, input bit cr);
      bit sa, sb;
      int d;
      sa = (aq.size() == S) ? aq[0] : 1'b0;
      sb = (bq.size() == S) ? bq[0] : 1'b0;
      aq.push_back(a); bq.push_back(b);
      if (aq.size() > S) begin
         void'(aq.pop_front());
         void'(bq.pop_front());
      end
      m_up = 0; m_down = 0; m_clr = 0; m_emit = 0;
      if (m_cnt >= N) begin
         d = (pos_of(m_deb_a, m_deb_b) - pos_of(m_prev_a, m_prev_b) + 4) % 4;
         if (d == 2 && m_err < 255) m_err++;
         if (en) begin
            if (d == 1) m_f++;
            if (d == 3) m_r++;
            m_win++;
            if (m_win == W) begin
               m_emit = 1;
               m_win  = 0;
               if (m_f >= m_r) m_up = m_f - m_r;
               else            m_down = m_r - m_f;
               m_clr  = m_pend | cr;
               m_pend = 0;
               m_f = 0; m_r = 0;
            end
         end
      end
      if (cr && !m_emit) m_pend = 1;
      m_prev_a = m_deb_a; m_prev_b = m_deb_b;
      if (sa != m_deb_a) begin
         m_run_a++;
         if (m_run_a == D) begin m_deb_a = sa; m_run_a = 0; end
      end else m_run_a = 0;
      if (sb != m_deb_b) begin
         m_run_b++;
         if (m_run_b == D) begin m_deb_b = sb; m_run_b = 0; end
      end else m_run_b = 0;
      m_cnt++;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step(qa, qb, enable, clear_req);
   end

   // Per-cycle comparison against the model
   bit chk_on = 0;
   always @(negedge clk) begin
      if (rst_n && chk_on) begin
         check("up", up, m_up);
         check("down", down, m_down);
         check("clear", clear, m_clr);
         check("err_count", err_count, m_err);
         check("up_down_exclusive", (up != 0 && down != 0), 0);
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   bit [1:0] codes [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
   int pos = 0;
   int e_up, e_down, e_clr, e_cyc, last_cyc, rel;

   task automatic move(input int step, input int hold);
      pos = (pos + step + 4) % 4;
      {qa, qb} = codes[pos];
      repeat (hold) @(negedge clk);
   endtask

   task automatic wait_emit();
      int n = 0;
      @(negedge clk);
      while (!m_emit && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!m_emit) begin
         tests++; fails++;
         $display("FAIL emit_timeout: no window emit within 300 cycles (cycle %0d)", cyc);
      end
      e_up = up; e_down = down; e_clr = clear; e_cyc = cyc;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      enable = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      rel = cyc;
      chk_on = 1;
      check("reset_up", up, 0);
      check("reset_down", down, 0);
      check("reset_clear", clear, 0);
      check("reset_err", err_count, 0);

      // First emit lands exactly SYNC_STAGES+DEBOUNCE+WINDOW edges after release.
      wait_emit();
      check("first_emit_time", e_cyc - rel, N + W);
      check("first_emit_clear", e_clr, 1);
      check("first_emit_up", e_up, 0);
      check("first_emit_down", e_down, 0);
      last_cyc = e_cyc;
      wait_emit();
      check("second_emit_clear", e_clr, 0);
      check("second_emit_period", e_cyc - last_cyc, W);

      // Three forward steps
      move(1, 6); move(1, 6); move(1, 6);
      wait_emit();
      check("fwd3_up", e_up, 3);
      check("fwd3_down", e_down, 0);

      // Two forward then five reverse
      move(1, 6); move(1, 6);
      repeat (5) move(-1, 6);
      wait_emit();
      check("rev_up", e_up, 0);
      check("rev_down", e_down, 3);

      // Glitch shorter than the debounce run
      qa = 1'b1;
      repeat (2) @(negedge clk);
      qa = 1'b0;
      wait_emit();
      check("glitch_err", err_count, 0);
      check("glitch_up", e_up, 0);
      check("glitch_down", e_down, 0);

      // Direct 00->11
      move(2, 6);
      repeat (8) @(negedge clk);
      check("illegal_err1", err_count, 1);
      wait_emit();
      check("illegal_up", e_up, 0);
      check("illegal_down", e_down, 0);

      // 300 more illegal transitions saturate the error count
      for (int i = 0; i < 300; i++) move(2, 4);
      repeat (10) @(negedge clk);
      check("err_saturated", err_count, 255);

      // clear_req mid-window with one forward step
      wait_emit();
      move(1, 6);
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
      wait_emit();
      check("clrreq_up", e_up, 1);
      check("clrreq_clear", e_clr, 1);

      // enable low for 10 cycles; the step inside that gap is not counted
      last_cyc = e_cyc;
      move(1, 6);
      repeat (6) @(negedge clk);
      enable = 1'b0;
      move(1, 10);
      enable = 1'b1;
      wait_emit();
      check("enable_gap_period", e_cyc - last_cyc, W + 10);
      check("enable_gap_up", e_up, 1);

      // Asynchronous reset mid-window with two pending steps
      move(1, 6); move(1, 6);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_err", err_count, 0);
      check("async_rst_up", up, 0);
      check("async_rst_down", down, 0);
      check("async_rst_clear", clear, 0);
      pos = 0;
      {qa, qb} = codes[pos];
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      rel = cyc;
      wait_emit();
      check("post_rst_emit_time", e_cyc - rel, N + W);
      check("post_rst_clear", e_clr, 1);
      check("post_rst_up", e_up, 0);
      check("post_rst_down", e_down, 0);

      // Random motion, holds, enable gaps and clear requests
      for (int it = 0; it < 400; it++) begin
         int r, h;
         r = $urandom_range(0, 99);
         h = $urandom_range(1, 9);
         enable    = ($urandom_range(0, 7) != 0);
         clear_req = ($urandom_range(0, 9) == 0);
         if (r < 42)      pos = (pos + 1) % 4;
         else if (r < 84) pos = (pos + 3) % 4;
         else if (r < 90) pos = (pos + 2) % 4;
         {qa, qb} = codes[pos];
         @(negedge clk);
         clear_req = 1'b0;
         repeat (h - 1) @(negedge clk);
      end
      enable = 1'b1;
      repeat (2 * W) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/quad_step_batcher.md
Name: quad_step_batcher

Overview:
- Upstream feeder for the up/down accumulator: decodes a two-phase quadrature encoder (qa/qb) into forward/reverse steps.
- Batches steps over a fixed window of cycles and emits one net up/down magnitude per window, with an optional clear, directly onto the accumulator's up/down/clear inputs.
- Guarantees up and down are never both nonzero, so downstream priority order is irrelevant.

Parameters:
SYNC_STAGES, 2, flops in each input synchronizer (>=2)
DEBOUNCE, 4, consecutive stable cycles required before a debounced level changes (>=1)
WINDOW, 16, cycles per batch window (>=2)
WIDTH, 32, width of up/down outputs

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
qa  input  1  encoder phase A, asynchronous to clk
qb  input  1  encoder phase B, asynchronous to clk
enable  input  1  1 = window counter runs and steps are counted
clear_req  input  1  one-cycle request to restart the accumulator at the next window boundary
up  output  WIDTH  net forward steps for the window; nonzero only in the emit cycle
down  output  WIDTH  net reverse steps for the window; nonzero only in the emit cycle
clear  output  1  one-cycle pulse, coincident with the emit cycle
err_count  output  8  saturating count of illegal (two-bit) transitions

Behaviour:
- Reset (rst_n=0, asynchronous): synchronizers, debounced levels, prev state, window count, batch counters, err_count all 0; up=down=0; clear=0; clear_pending=1; FSM=INIT.
- Synchronizer: SYNC_STAGES flops per channel; no logic between stages.
- Debounce per channel: if the synced level differs from the debounced level for DEBOUNCE consecutive cycles, the debounced level takes the new value; any agreement resets the run counter.
- FSM INIT: ignore all transitions; load prev state from the debounced {a,b}; go to RUN after SYNC_STAGES+DEBOUNCE cycles. RUN: normal operation. No other states.
- Decode in RUN (debounced {a,b} vs prev, every cycle, irrespective of enable): forward sequence 00->01->11->10->00; reverse is the opposite sequence; equal = no step; both bits changed = illegal: err_count += 1, saturating at 255, no step. Prev is always updated.
- Steps count only when enable=1.
  - fwd_cnt and rev_cnt are $clog2(WINDOW+1) bits each and saturate.
- Window counter runs 0..WINDOW-1 while enable=1 and holds while enable=0.
- Emit cycle, registered, on the cycle after the window counter equals WINDOW-1 with enable=1:
  - A step decoded in the terminal cycle is included in that window.
  - If fwd>=rev: up=fwd-rev, down=0. Else up=0, down=rev-fwd. Values are zero-extended to WIDTH.
  - clear=clear_pending; clear_pending then drops to 0.
  - Batch counters restart at 0, or 1 if a step lands on the same cycle as the restart.
- Outside the emit cycle: up=down=0, clear=0.
- clear_req=1 on any cycle sets clear_pending. If it coincides with the terminal cycle, it applies to that emit.
- Latency: one registered cycle from the terminal count to the outputs.
- Reset asserted mid-window discards the partial batch. The first window after reset always emits clear=1.

Decomposition:
- Package quad_pkg:
  - state enum {INIT, RUN};
  - 2-bit phase constants PH_00/01/11/10;
  - a function returning step direction {NONE, FWD, REV, ILLEGAL} from (prev, curr).
- Sub-module debounce_sync (synchronizer + debounce, one bit), instantiated twice.

Test Plan:
- Reset release with qa=qb=0, enable=1, no motion -> first emit at cycle SYNC_STAGES+DEBOUNCE+WINDOW (±1, documented in the bench): up=0, down=0, clear=1; the next window gives clear=0.
- 3 forward steps (00->01->11->10, each held 6 cycles) inside one window -> emit up=3, down=0.
- 2 forward then 5 reverse steps in one window -> up=0, down=3; never both nonzero.
- 2-cycle glitch on qa (< DEBOUNCE) -> no step, err_count unchanged; direct 00->11 held 6 cycles -> err_count=1, up=down=0; 300 illegal transitions -> err_count=255.
- clear_req pulse mid-window with 1 forward step -> emit up=1, clear=1. enable low for 10 cycles mid-window -> emit delayed by 10 cycles and steps during that period not counted.
- rst_n asserted asynchronously mid-window with 2 pending steps -> outputs 0 immediately; after release, FSM re-enters INIT and the first emit has clear=1 with those steps discarded.
